// File: rtl/systolic_tile_sched_if.sv
// Control/command bundle for systolic_tile_sched.
//   master : the scheduler (drives the command stream, status and counters)
//   slave  : control register file + systolic array side
// Signals:
//   start, abort, m_tiles, n_tiles, k_tiles : job control into the scheduler
//   cmd_valid/cmd_ready, cmd_op, cmd_row, cmd_col, cmd_k, cmd_acc : command stream
//   busy, done, err, mac_count, stall_count : status back to the register file
interface systolic_tile_sched_if #(
    parameter int unsigned TILE_BITS = 4,
    parameter int unsigned CNT_W     = 16
);
    logic                 start;
    logic                 abort;
    logic [TILE_BITS-1:0] m_tiles;
    logic [TILE_BITS-1:0] n_tiles;
    logic [TILE_BITS-1:0] k_tiles;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [TILE_BITS-1:0] cmd_row;
    logic [TILE_BITS-1:0] cmd_col;
    logic [TILE_BITS-1:0] cmd_k;
    logic                 cmd_acc;

    logic                 busy;
    logic                 done;
    logic                 err;
    logic [CNT_W-1:0]     mac_count;
    logic [CNT_W-1:0]     stall_count;

    modport master (
        input  start, abort, m_tiles, n_tiles, k_tiles, cmd_ready,
        output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_k, cmd_acc,
        output busy, done, err, mac_count, stall_count
    );

    modport slave (
        output start, abort, m_tiles, n_tiles, k_tiles, cmd_ready,
        input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_k, cmd_acc,
        input  busy, done, err, mac_count, stall_count
    );
endinterface

// File: rtl/systolic_tile_sched.sv
// Tile scheduler for the 32x32 systolic matmul datapath.
// Walks an M x N grid of output tiles (i outer, j middle, k inner reduction)
// and issues LOAD_A, LOAD_B, MAC per k step followed by one DRAIN per (i,j)
// over a valid/ready command handshake. Reports done/err pulses, busy, and
// MAC / stall counters (saturating, cleared on an accepted start).
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : systolic_tile_sched_if.master (job control, command stream, status)
// Configuration macro:
//   SCHED_STALL_CNT_EN : when defined, stall_count counts cycles with
//                        cmd_valid && !cmd_ready; otherwise it is tied to 0.
module systolic_tile_sched #(
    parameter int unsigned TILE_BITS = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_tile_sched_if.master bus
);

    localparam logic [1:0] OP_LOAD_A = 2'b00;
    localparam logic [1:0] OP_LOAD_B = 2'b01;
    localparam logic [1:0] OP_MAC    = 2'b10;
    localparam logic [1:0] OP_DRAIN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_n;

    // Latched job dimensions
    logic [TILE_BITS-1:0] m_r, n_r, k_r;
    // Loop indices and their next values
    logic [TILE_BITS-1:0] i_r, j_r, kk_r;
    logic [TILE_BITS-1:0] i_n, j_n, kk_n;

    logic fire_c;
    logic accept_c;
    logic reject_c;
    logic dims_ok_c;

    // Next values of the registered command outputs
    logic                 cmd_valid_n;
    logic [1:0]           cmd_op_n;
    logic [TILE_BITS-1:0] cmd_row_n;
    logic [TILE_BITS-1:0] cmd_col_n;
    logic [TILE_BITS-1:0] cmd_k_n;
    logic                 cmd_acc_n;

    assign fire_c    = bus.cmd_valid && bus.cmd_ready;
    assign dims_ok_c = (bus.m_tiles != '0) && (bus.n_tiles != '0) && (bus.k_tiles != '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, index advance and command decode
    always_comb begin
        state_n     = state;
        i_n         = i_r;
        j_n         = j_r;
        kk_n        = kk_r;
        accept_c    = 1'b0;
        reject_c    = 1'b0;
        cmd_valid_n = 1'b0;
        cmd_op_n    = OP_LOAD_A;
        cmd_row_n   = '0;
        cmd_col_n   = '0;
        cmd_k_n     = '0;
        cmd_acc_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (dims_ok_c) begin
                        accept_c = 1'b1;
                        state_n  = S_LOAD_A;
                        i_n      = '0;
                        j_n      = '0;
                        kk_n     = '0;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            S_LOAD_A: begin
                if (fire_c) begin
                    state_n = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (fire_c) begin
                    state_n = S_MAC;
                end
            end
            S_MAC: begin
                if (fire_c) begin
                    if (kk_r != k_r - TILE_BITS'(1)) begin
                        kk_n    = kk_r + TILE_BITS'(1);
                        state_n = S_LOAD_A;
                    end else begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fire_c) begin
                    kk_n = '0;
                    if (j_r == n_r - TILE_BITS'(1)) begin
                        j_n = '0;
                        if (i_r == m_r - TILE_BITS'(1)) begin
                            state_n = S_DONE;
                        end else begin
                            i_n     = i_r + TILE_BITS'(1);
                            state_n = S_LOAD_A;
                        end
                    end else begin
                        j_n     = j_r + TILE_BITS'(1);
                        state_n = S_LOAD_A;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort overrides any in-flight progress; a same-cycle handshake still counts
        if (bus.abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
        end

        // Command outputs are decoded from the next state so they can be registered;
        // during a stall state and indices hold, so the fields hold too.
        case (state_n)
            S_LOAD_A: begin
                cmd_valid_n = 1'b1;
                cmd_op_n    = OP_LOAD_A;
                cmd_row_n   = i_n;
                cmd_k_n     = kk_n;
            end
            S_LOAD_B: begin
                cmd_valid_n = 1'b1;
                cmd_op_n    = OP_LOAD_B;
                cmd_col_n   = j_n;
                cmd_k_n     = kk_n;
            end
            S_MAC: begin
                cmd_valid_n = 1'b1;
                cmd_op_n    = OP_MAC;
                cmd_row_n   = i_n;
                cmd_col_n   = j_n;
                cmd_k_n     = kk_n;
                cmd_acc_n   = (kk_n != '0);
            end
            S_DRAIN: begin
                cmd_valid_n = 1'b1;
                cmd_op_n    = OP_DRAIN;
                cmd_row_n   = i_n;
                cmd_col_n   = j_n;
            end
            default: begin
                cmd_valid_n = 1'b0;
            end
        endcase
    end

    // Job dimensions and loop indices
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r  <= '0;
            n_r  <= '0;
            k_r  <= '0;
            i_r  <= '0;
            j_r  <= '0;
            kk_r <= '0;
        end else begin
            if (accept_c) begin
                m_r <= bus.m_tiles;
                n_r <= bus.n_tiles;
                k_r <= bus.k_tiles;
            end
            i_r  <= i_n;
            j_r  <= j_n;
            kk_r <= kk_n;
        end
    end

    // Registered command and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cmd_valid <= 1'b0;
            bus.cmd_op    <= OP_LOAD_A;
            bus.cmd_row   <= '0;
            bus.cmd_col   <= '0;
            bus.cmd_k     <= '0;
            bus.cmd_acc   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.cmd_valid <= cmd_valid_n;
            bus.cmd_op    <= cmd_op_n;
            bus.cmd_row   <= cmd_row_n;
            bus.cmd_col   <= cmd_col_n;
            bus.cmd_k     <= cmd_k_n;
            bus.cmd_acc   <= cmd_acc_n;
            bus.busy      <= (state_n != S_IDLE);
            bus.done      <= (state_n == S_DONE);
            bus.err       <= reject_c;
        end
    end

    // Accepted MAC commands, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mac_count <= '0;
        end else if (accept_c) begin
            bus.mac_count <= '0;
        end else if (fire_c && (state == S_MAC) && (bus.mac_count != '1)) begin
            bus.mac_count <= bus.mac_count + CNT_W'(1);
        end
    end

`ifdef SCHED_STALL_CNT_EN
    // Back-pressure cycles, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.stall_count <= '0;
        end else if (accept_c) begin
            bus.stall_count <= '0;
        end else if (bus.cmd_valid && !bus.cmd_ready && (bus.stall_count != '1)) begin
            bus.stall_count <= bus.stall_count + CNT_W'(1);
        end
    end
`else
    assign bus.stall_count = '0;
`endif

endmodule
